// File: rtl/mcpu_core.sv
// mcpu_core: multi-cycle CPU with 16-bit instructions and req/ready instruction and data ports.
// Optional feature macro MCPU_HALT_EN: opcode 1111111 halts the core until reset.
module mcpu_core #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [15:0]   imem_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ready,
    input  logic [DW-1:0] dmem_rdata,
    output logic [AW-1:0] pc,
    output logic          retire,
    output logic          halted
);
    localparam logic [6:0] OP_MOVA = 7'b0000000;
    localparam logic [6:0] OP_INC  = 7'b0000001;
    localparam logic [6:0] OP_ADD  = 7'b0000010;
    localparam logic [6:0] OP_SUB  = 7'b0000101;
    localparam logic [6:0] OP_DEC  = 7'b0000110;
    localparam logic [6:0] OP_AND  = 7'b0001000;
    localparam logic [6:0] OP_OR   = 7'b0001001;
    localparam logic [6:0] OP_XOR  = 7'b0001010;
    localparam logic [6:0] OP_NOT  = 7'b0001011;
    localparam logic [6:0] OP_MOVB = 7'b0001100;
    localparam logic [6:0] OP_SHR  = 7'b0001101;
    localparam logic [6:0] OP_SHL  = 7'b0001110;
    localparam logic [6:0] OP_LDI  = 7'b1001100;
    localparam logic [6:0] OP_ADI  = 7'b1000010;
    localparam logic [6:0] OP_LD   = 7'b0010000;
    localparam logic [6:0] OP_ST   = 7'b0100000;
    localparam logic [6:0] OP_BRZ  = 7'b1100000;
    localparam logic [6:0] OP_BRN  = 7'b1100001;
    localparam logic [6:0] OP_JMP  = 7'b1110000;
`ifdef MCPU_HALT_EN
    localparam logic [6:0] OP_HALT = 7'b1111111;
`endif

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t             state;
    logic [15:0]        ir;
    logic [DW-1:0]      regs [8];

    logic [6:0]         opcode;
    logic [2:0]         dr;
    logic [2:0]         sa;
    logic [2:0]         sb;
    logic [DW-1:0]      ra;
    logic [DW-1:0]      rb;
    logic [DW-1:0]      k;
    logic signed [5:0]  offset;
    logic [AW-1:0]      pc_inc;
    logic [AW-1:0]      pc_br;
    logic [AW-1:0]      pc_next;
    logic [DW-1:0]      alu_res;
    logic               alu_wr;
    logic               is_mem;

    assign opcode    = ir[15:9];
    assign dr        = ir[8:6];
    assign sa        = ir[5:3];
    assign sb        = ir[2:0];
    assign ra        = regs[sa];
    assign rb        = regs[sb];
    assign k         = DW'(sb);
    assign offset    = {ir[8:6], ir[2:0]};
    assign pc_inc    = pc + AW'(1);
    // Signed cast sign-extends (or truncates) the 6-bit offset to the PC width.
    assign pc_br     = pc + AW'(offset);
    assign is_mem    = (opcode == OP_LD) || (opcode == OP_ST);
    assign imem_addr = pc;

    // ALU result and whether the opcode writes R[DR].
    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b1;
        case (opcode)
            OP_MOVA: alu_res = ra;
            OP_INC:  alu_res = ra + DW'(1);
            OP_ADD:  alu_res = ra + rb;
            OP_SUB:  alu_res = ra - rb;
            OP_DEC:  alu_res = ra - DW'(1);
            OP_AND:  alu_res = ra & rb;
            OP_OR:   alu_res = ra | rb;
            OP_XOR:  alu_res = ra ^ rb;
            OP_NOT:  alu_res = ~ra;
            OP_MOVB: alu_res = rb;
            OP_SHR:  alu_res = rb >> 1;
            OP_SHL:  alu_res = rb << 1;
            OP_LDI:  alu_res = k;
            OP_ADI:  alu_res = ra + k;
            default: alu_wr  = 1'b0;
        endcase
    end

    // Next PC for non-memory instructions; everything but control flow falls through.
    always_comb begin
        pc_next = pc_inc;
        case (opcode)
            OP_BRZ:  if (ra == '0) pc_next = pc_br;
            OP_BRN:  if (ra[DW-1]) pc_next = pc_br;
            OP_JMP:  pc_next = AW'(ra);
            default: pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ready) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= (opcode == OP_ST);
                        dmem_addr  <= ra;
                        dmem_wdata <= rb;
                        state      <= S_MEM;
                    end
`ifdef MCPU_HALT_EN
                    else if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        retire <= 1'b1;
                        state  <= S_HALT;
                    end
`endif
                    else begin
                        if (alu_wr) regs[dr] <= alu_res;
                        pc       <= pc_next;
                        retire   <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (!dmem_we) regs[dr] <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc_inc;
                        retire   <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_core.sv
// tb_mcpu_core: directed and random programs checked against an ISA-level model with wait-state memories.
`timescale 1ns/1ps
module tb_mcpu_core;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    localparam logic [6:0] OP_ADD  = 7'b0000010;
    localparam logic [6:0] OP_DEC  = 7'b0000110;
    localparam logic [6:0] OP_SHR  = 7'b0001101;
    localparam logic [6:0] OP_SHL  = 7'b0001110;
    localparam logic [6:0] OP_LDI  = 7'b1001100;
    localparam logic [6:0] OP_LD   = 7'b0010000;
    localparam logic [6:0] OP_ST   = 7'b0100000;
    localparam logic [6:0] OP_BRN  = 7'b1100001;
    localparam logic [6:0] OP_JMP  = 7'b1110000;
    localparam logic [6:0] OP_NOP  = 7'b0000011;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic [15:0]   imem_data;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ready;
    logic [DW-1:0] dmem_rdata;
    logic [AW-1:0] pc;
    logic          retire;
    logic          halted;

    mcpu_core #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .retire(retire), .halted(halted)
    );

    logic [15:0] imem   [256];
    logic [7:0]  dmem   [256];
    logic [7:0]  m_dmem [256];
    int          m_r    [8];
    int          m_pc;
    bit          m_halted;

    int n_checks = 0;
    int n_fail   = 0;
    int iwait = 0;
    int dwait = 0;
    bit rand_waits = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [6:0] op, input int dr, input int sa, input int sb);
        return {op, 3'(dr), 3'(sa), 3'(sb)};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [6:0] ops [21] = '{7'b0000000, 7'b0000001, 7'b0000010, 7'b0000101, 7'b0000110,
                                 7'b0001000, 7'b0001001, 7'b0001010, 7'b0001011, 7'b0001100,
                                 7'b0001101, 7'b0001110, 7'b1001100, 7'b1000010, 7'b0010000,
                                 7'b0100000, 7'b1100000, 7'b1100001, 7'b1110000, 7'b0000011,
                                 7'b0010000};
        return {ops[$urandom_range(0, 20)], 9'($urandom)};
    endfunction

    // ISA-level reference: one whole instruction per call, plain integer arithmetic.
    task automatic model_step();
        logic [15:0] ins;
        logic [6:0]  op;
        int dr, sa, sb, a, b, off, npc, res;
        bit wr;
        ins = imem[m_pc];
        op  = ins[15:9];
        dr  = int'(ins[8:6]);
        sa  = int'(ins[5:3]);
        sb  = int'(ins[2:0]);
        a   = m_r[sa];
        b   = m_r[sb];
        off = int'({ins[8:6], ins[2:0]});
        if (off >= 32) off -= 64;
        wr  = 1;
        res = 0;
        npc = m_pc + 1;
        case (op)
            7'b0000000: res = a;
            7'b0000001: res = a + 1;
            7'b0000010: res = a + b;
            7'b0000101: res = a - b;
            7'b0000110: res = a - 1;
            7'b0001000: res = a & b;
            7'b0001001: res = a | b;
            7'b0001010: res = a ^ b;
            7'b0001011: res = 255 - a;
            7'b0001100: res = b;
            7'b0001101: res = b / 2;
            7'b0001110: res = b * 2;
            7'b1001100: res = sb;
            7'b1000010: res = a + sb;
            7'b0010000: res = int'(m_dmem[a]);
            7'b0100000: begin m_dmem[a] = 8'(b); wr = 0; end
            7'b1100000: begin wr = 0; if (a == 0) npc = m_pc + off; end
            7'b1100001: begin wr = 0; if (a >= 128) npc = m_pc + off; end
            7'b1110000: begin wr = 0; npc = a; end
`ifdef MCPU_HALT_EN
            7'b1111111: begin wr = 0; npc = m_pc; m_halted = 1; end
`endif
            default: wr = 0;
        endcase
        if (wr) m_r[dr] = res & 255;
        m_pc = npc & 255;
    endtask

    // Memory responders: ready comes (wait + 1) cycles after req rises.
    initial begin : responder
        int icnt, dcnt, icur, dcur;
        icnt = 0; dcnt = 0; icur = 0; dcur = 0;
        imem_ready = 0; imem_data = '0; dmem_ready = 0; dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ready) begin
                imem_ready = 0;
                icnt = 0;
            end else if (imem_req) begin
                if (icnt == 0) icur = rand_waits ? int'($urandom_range(0, 2)) : iwait;
                icnt++;
                if (icnt >= icur + 2) begin
                    imem_ready = 1;
                    imem_data  = imem[imem_addr];
                end
            end else begin
                icnt = 0;
            end
            if (dmem_ready) begin
                dmem_ready = 0;
                dcnt = 0;
            end else if (dmem_req) begin
                if (dcnt == 0) dcur = rand_waits ? int'($urandom_range(0, 3)) : dwait;
                dcnt++;
                if (dcnt >= dcur + 2) begin
                    dmem_ready = 1;
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = dmem[dmem_addr];
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    // Steps the model on each retire and checks PC, fetch address and data-port payload.
    initial begin : monitor
        bit          dreq_q;
        logic [7:0]  cap_addr, cap_wdata;
        logic        cap_we;
        logic [15:0] ins;
        dreq_q = 0; cap_addr = '0; cap_wdata = '0; cap_we = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < 8; i++) m_r[i] = 0;
                m_pc = 0;
                m_halted = 0;
                dreq_q = 0;
            end else begin
                if (retire) begin
                    if (m_halted) begin
                        check("retire_after_halt", 32'(retire), 0);
                    end else begin
                        model_step();
                        check("pc", 32'(pc), 32'(m_pc));
                        check("halted", 32'(halted), 32'(m_halted));
                    end
                end
                if (imem_req) check("imem_addr", 32'(imem_addr), 32'(m_pc));
                if (dmem_req && !dreq_q) begin
                    ins = imem[m_pc];
                    check("dmem_addr", 32'(dmem_addr), 32'(m_r[int'(ins[5:3])]));
                    check("dmem_we", 32'(dmem_we), 32'(ins[15:9] == OP_ST));
                    if (dmem_we) check("dmem_wdata", 32'(dmem_wdata), 32'(m_r[int'(ins[2:0])]));
                    cap_addr = dmem_addr; cap_we = dmem_we; cap_wdata = dmem_wdata;
                end else if (dmem_req) begin
                    check("dmem_addr_hold", 32'(dmem_addr), 32'(cap_addr));
                    check("dmem_we_hold", 32'(dmem_we), 32'(cap_we));
                    if (cap_we) check("dmem_wdata_hold", 32'(dmem_wdata), 32'(cap_wdata));
                end
                dreq_q = dmem_req;
            end
        end
    end

    task automatic hold_reset();
        reset = 1;
        iwait = 0; dwait = 0; rand_waits = 0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = enc(OP_NOP, 0, 0, 0);
            dmem[i] = '0;
            m_dmem[i] = '0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_retire(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!retire && cyc < 64);
        if (!retire) check("retire_timeout", 32'(retire), 1);
    endtask

    task automatic run_retires(input int n);
        int c;
        repeat (n) wait_retire(c);
    endtask

    initial begin : stimulus
        int c, mism;
        bit found;
        reset = 1;

        // Reset values, then LDI/LDI/ADD with zero-wait memories.
        hold_reset();
        check("rst_pc", 32'(pc), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_dmem_req", 32'(dmem_req), 0);
        check("rst_dmem_we", 32'(dmem_we), 0);
        check("rst_retire", 32'(retire), 0);
        check("rst_halted", 32'(halted), 0);
        imem[0] = enc(OP_LDI, 1, 0, 5);
        imem[1] = enc(OP_LDI, 2, 0, 3);
        imem[2] = enc(OP_ADD, 3, 1, 2);
        imem[3] = enc(OP_ST, 0, 0, 3);
        reset = 0;
        wait_retire(c); check("lat_first", 32'(c), 4);
        wait_retire(c); check("lat_alu", 32'(c), 3);
        wait_retire(c); check("lat_alu", 32'(c), 3);
        check("pc_after_add", 32'(pc), 3);
        wait_retire(c); check("lat_st", 32'(c), 5);
        check("add_result", 32'(dmem[0]), 8);

        // Backward branch on negative: DEC 0 -> 0xFF, BRN -1 returns to the DEC.
        hold_reset();
        imem[0] = enc(OP_LDI, 1, 0, 0);
        imem[1] = enc(OP_DEC, 1, 1, 0);
        imem[2] = enc(OP_BRN, 7, 1, 7);
        reset = 0;
        run_retires(3);
        check("brn_taken_pc", 32'(pc), 1);
        run_retires(1);
        check("brn_loop_pc", 32'(pc), 2);

        // SHR of 0x80 is a logical shift.
        hold_reset();
        imem[0] = enc(OP_LDI, 1, 0, 1);
        for (int i = 1; i <= 7; i++) imem[i] = enc(OP_SHL, 1, 0, 1);
        imem[8] = enc(OP_SHR, 3, 0, 1);
        imem[9] = enc(OP_ST, 0, 0, 3);
        reset = 0;
        run_retires(10);
        check("shr_0x80", 32'(dmem[0]), 32'h40);

        // Store then load through a data memory with four wait states.
        hold_reset();
        dwait = 4;
        imem[0] = enc(OP_LDI, 1, 0, 6);
        imem[1] = enc(OP_LDI, 2, 0, 5);
        imem[2] = enc(OP_ST, 0, 2, 1);
        imem[3] = enc(OP_LD, 4, 2, 0);
        imem[4] = enc(OP_ST, 0, 0, 4);
        reset = 0;
        run_retires(2);
        wait_retire(c); check("lat_st_wait", 32'(c), 9);
        wait_retire(c); check("lat_ld_wait", 32'(c), 9);
        wait_retire(c); check("lat_st2_wait", 32'(c), 9);
        check("st_value", 32'(dmem[5]), 6);
        check("ld_value", 32'(dmem[0]), 6);

        // PC wrap: jump to the last address, one NOP, next fetch from 0.
        hold_reset();
        imem[0] = enc(OP_LDI, 1, 0, 0);
        imem[1] = enc(OP_DEC, 1, 1, 0);
        imem[2] = enc(OP_JMP, 0, 1, 0);
        reset = 0;
        run_retires(3);
        check("jmp_pc", 32'(pc), 255);
        run_retires(1);
        check("wrap_pc", 32'(pc), 0);
        check("wrap_fetch_req", 32'(imem_req), 1);
        check("wrap_fetch_addr", 32'(imem_addr), 0);

        // Reset lands on the edge where a fetch completes.
        hold_reset();
        imem[0] = enc(OP_ST, 0, 1, 2);
        imem[1] = enc(OP_LDI, 1, 0, 5);
        imem[2] = enc(OP_LDI, 2, 0, 3);
        imem[3] = enc(OP_JMP, 0, 0, 0);
        reset = 0;
        run_retires(3);
        check("pre_reset_pc", 32'(pc), 3);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_ready) begin found = 1; break; end
            @(negedge clk);
        end
        check("handshake_seen", 32'(found), 1);
        reset = 1;
        @(negedge clk);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_imem_req", 32'(imem_req), 0);
        check("midrst_dmem_req", 32'(dmem_req), 0);
        check("midrst_retire", 32'(retire), 0);
        @(negedge clk);
        reset = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dmem_req) begin found = 1; break; end
        end
        check("midrst_dmem_seen", 32'(found), 1);
        check("midrst_reg_addr", 32'(dmem_addr), 0);
        check("midrst_reg_data", 32'(dmem_wdata), 0);

        // Halt opcode at PC 2.
        hold_reset();
        imem[0] = enc(OP_LDI, 1, 0, 1);
        imem[1] = enc(OP_LDI, 2, 0, 2);
        imem[2] = {OP_HALT, 9'h1ff};
        imem[3] = enc(OP_LDI, 3, 0, 1);
        reset = 0;
        run_retires(3);
`ifdef MCPU_HALT_EN
        check("halt_flag", 32'(halted), 1);
        check("halt_pc", 32'(pc), 2);
        repeat (20) begin
            @(negedge clk);
            check("halt_no_fetch", 32'(imem_req), 0);
        end
        check("halt_pc_hold", 32'(pc), 2);
`else
        check("halt_nop_pc", 32'(pc), 3);
        check("halt_flag_off", 32'(halted), 0);
`endif

        // Random program with random wait states.
        hold_reset();
        for (int i = 0; i < 256; i++) begin
            imem[i]   = rand_instr();
            dmem[i]   = 8'($urandom);
            m_dmem[i] = dmem[i];
        end
        rand_waits = 1;
        reset = 0;
        run_retires(400);
        mism = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) mism++;
        check("random_dmem", 32'(mism), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
